lsu: RTL and testbench
======================

# lsu

Load/store unit for the pipelined core's memory stage and the initiator side of the data-memory port. It accepts one load or store request at a time from the pipeline through a valid/ready handshake and drives the data memory's address, write-enable, addressing-control and write-data inputs for exactly one access cycle. It registers the memory read data and returns a response (load data, store acknowledge or fault) through a second valid/ready handshake.

## Interface
- DATA_WIDTH, 32, address/data width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  DATA_WIDTH  effective byte address
- req_wdata  in  DATA_WIDTH  store data, low bytes used
- resp_valid  out  1  response valid
- resp_ready  in  1  pipeline accepts response
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults
- resp_fault  out  1  illegal or misaligned request
- mem_A  out  DATA_WIDTH  memory address
- mem_WE  out  1  memory write enable
- mem_AddressingControl  out  3  [1:0] 00 byte, 01 half, 10 word; [2] zero-extend
- mem_WD  out  DATA_WIDTH  memory write data
- mem_RD  in  DATA_WIDTH  combinational memory read data

## Operation
- States: IDLE, ACCESS, RESP.
- req_ready = (state==IDLE) || (state==RESP && resp_ready), forced to 0 while rst is high.
- Acceptance (req_valid && req_ready):
  - Latch we, funct3, addr and wdata.
  - Evaluate legality. Illegal: load funct3 011/110/111; store funct3 with bit 2 set or equal to 011.
  - Legal request: go to ACCESS. Illegal request: go to RESP with fault=1, rdata=0, no memory access.
- ACCESS (exactly 1 cycle):
  - mem_A = latched addr; mem_AddressingControl = latched funct3; mem_WD = latched wdata; mem_WE = latched we.
  - Loads: capture mem_RD into resp_rdata. Stores: resp_rdata = 0.
  - Go to RESP.
- RESP:
  - resp_valid = 1. resp_rdata and resp_fault are held stable until the handshake completes.
  - resp_valid && resp_ready with a new request accepted in the same cycle: go to ACCESS (or to RESP if the new request faults).
  - resp_valid && resp_ready without a new request: go to IDLE.
- mem_WE is 1 only in ACCESS for stores. It is never asserted for faults, loads or IDLE/RESP.
- Outside ACCESS, mem_A/mem_WD/mem_AddressingControl hold their latched values; their contents are don't-care.

## Timing
- Reset: state IDLE, resp_valid 0, resp_fault 0, resp_rdata 0, mem_WE 0, mem_A 0, mem_WD 0, mem_AddressingControl 0, req_ready 0 during reset and 1 in the first cycle after reset.
- Latency: acceptance edge → ACCESS cycle → resp_valid high on the next cycle (2 cycles). Faults: resp_valid high 1 cycle after acceptance.
- Throughput: one request per 2 cycles with resp_ready held high.
- Reset during ACCESS: a store write in that cycle is suppressed because mem_WE is gated by !rst. Any pending response is discarded.
- resp_ready may be asserted while resp_valid is low; it has no effect then.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Half accesses with addr[0]≠0 are faults.
  - Word accesses with addr[1:0]≠0 are faults.
  - Fault requests are handled as illegal: go to RESP, no memory access.
- LSU_MISALIGN_TRAP_EN undefined: misaligned accesses are legal and are passed through unchanged, because the memory assembles consecutive bytes.

## Structure
- lsu_pkg:
  - State enum lsu_state_t.
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - Addressing-mode constants.
- Sub-module lsu_check: combinational legality and misalignment check. Inputs: we, funct3, addr[1:0]. Output: fault. The misalignment term is conditioned on LSU_MISALIGN_TRAP_EN.

## Test plan
- Store then load: sw 0xDEADBEEF @0x100, then lw @0x100 → resp_rdata 0xDEADBEEF, fault 0. mem_WE high for exactly 1 cycle.
- Load extension: lb @0x103 → 0xFFFFFFDE; lbu @0x103 → 0x000000DE; lh @0x102 → 0xFFFFDEAD; lhu @0x102 → 0x0000DEAD.
- Illegal requests:
  - Load funct3=011 → fault 1, rdata 0, resp_valid 1 cycle after acceptance, no mem_WE.
  - With macro: sh @0x101 → fault 1, memory unchanged.
  - Without macro: sh 0xABCD @0x101 succeeds, and lhu @0x101 → 0x0000ABCD.
- Backpressure: hold resp_ready=0 for 3 cycles in RESP → resp_valid/rdata stable and req_ready 0. Release with req_valid high → new request enters ACCESS on the next cycle.
- Back-to-back: resp_ready=1 and req_valid=1 continuously for 4 loads → one response every 2 cycles, all data correct.
- Reset mid-operation: assert rst during the ACCESS cycle of sw 0x11223344 @0x200 → no write occurs (lw @0x200 returns the old value). All outputs take their reset values on the next edge.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RISC-V
// load/store funct3 encodings, memory addressing modes and the funct3 legality rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] AC_BYTE = 2'b00;
  localparam logic [1:0] AC_HALF = 2'b01;
  localparam logic [1:0] AC_WORD = 2'b10;

  // Stores have no unsigned variants; loads reject the unused encodings.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3[2] || (f3 == 3'b011);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_check.sv
// Combinational request legality check. Misaligned half/word accesses fault only
// when LSU_MISALIGN_TRAP_EN is defined; otherwise the memory handles them.
module lsu_check
  import lsu_pkg::*;
(
  input  logic       we_i,
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  output logic       fault_o
);

  logic misalign;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (funct3_i[1:0])
      AC_HALF: misalign = addr_lo_i[0];
      AC_WORD: misalign = |addr_lo_i;
      default: misalign = 1'b0;
    endcase
  end
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_lo_i;
  assign misalign       = 1'b0;
`endif

  assign fault_o = f3_illegal(we_i, funct3_i) || misalign;

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, a single memory access cycle, then a
// held response. Optional misalignment trapping via LSU_MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // valid/ready: a transfer happens on a rising edge where both valid and ready
  // are high; the sender holds its payload stable while valid is high and ready low.
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic [DATA_WIDTH-1:0] mem_A,
  output logic                  mem_WE,
  output logic [2:0]            mem_AddressingControl,
  output logic [DATA_WIDTH-1:0] mem_WD,
  input  logic [DATA_WIDTH-1:0] mem_RD,
  output lsu_state_t            dbg_state
);

  lsu_state_t            state_q,  state_d;
  logic                  we_q,     we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] addr_q,   addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic                  fault_q,  fault_d;

  logic req_fault;
  logic accept;
  logic take_req;

  lsu_check u_check (
    .we_i      (req_we),
    .funct3_i  (req_funct3),
    .addr_lo_i (req_addr[1:0]),
    .fault_o   (req_fault)
  );

  assign req_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_RESP) && resp_ready));
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    take_req = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) take_req = 1'b1;
      end
      S_ACCESS: begin
        rdata_d = we_q ? '0 : mem_RD;
        fault_d = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          if (accept) take_req = 1'b1;
          else        state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Faulting requests skip the memory cycle and respond immediately.
    if (take_req) begin
      we_d     = req_we;
      funct3_d = req_funct3;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
      rdata_d  = '0;
      fault_d  = req_fault;
      state_d  = req_fault ? S_RESP : S_ACCESS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  assign resp_valid            = (state_q == S_RESP);
  assign resp_rdata            = rdata_q;
  assign resp_fault            = fault_q;
  assign mem_A                 = addr_q;
  assign mem_WD                = wdata_q;
  assign mem_AddressingControl = funct3_q;
  assign mem_WE                = (state_q == S_ACCESS) && we_q && !rst;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a byte-addressed little-endian memory model and a
// response scoreboard (expected data, fault and latency queued at acceptance).
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;
  logic [2:0]  mem_AddressingControl;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int we_cnt = 0;

  logic [31:0] exp_q[$];
  logic        exp_fault_q[$];
  int          exp_lat_q[$];
  int          acc_q[$];
  int          resp_cyc_q[$];

  lsu #(.DATA_WIDTH(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_we                (req_we),
    .req_funct3            (req_funct3),
    .req_addr              (req_addr),
    .req_wdata             (req_wdata),
    .resp_valid            (resp_valid),
    .resp_ready            (resp_ready),
    .resp_rdata            (resp_rdata),
    .resp_fault            (resp_fault),
    .mem_A                 (mem_A),
    .mem_WE                (mem_WE),
    .mem_AddressingControl (mem_AddressingControl),
    .mem_WD                (mem_WD),
    .mem_RD                (mem_RD),
    .dbg_state             (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_WE) we_cnt <= we_cnt + 1;

  // ---------------- memory model ----------------
  logic [7:0] mem [0:1023];
  logic       mem_loaded = 1'b0;
  logic [9:0] ma;
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    ma = mem_A[9:0];
    b0 = mem[ma];
    b1 = mem[ma + 10'd1];
    b2 = mem[ma + 10'd2];
    b3 = mem[ma + 10'd3];
    case (mem_AddressingControl[1:0])
      2'b00:   mem_RD = mem_AddressingControl[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   mem_RD = mem_AddressingControl[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: mem_RD = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h200] <= 8'h0D;
      mem[10'h201] <= 8'hF0;
      mem[10'h202] <= 8'hFE;
      mem[10'h203] <= 8'hCA;
      mem_loaded   <= 1'b1;
    end else if (mem_WE) begin
      mem[ma] <= mem_WD[7:0];
      if (mem_AddressingControl[1:0] != 2'b00) mem[ma + 10'd1] <= mem_WD[15:8];
      if (mem_AddressingControl[1:0] == 2'b10) begin
        mem[ma + 10'd2] <= mem_WD[23:16];
        mem[ma + 10'd3] <= mem_WD[31:24];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on each completed response handshake.
  always @(negedge clk) begin
    #3;
    if (rst === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL unexpected_resp: observed rdata %h fault %b expected no response",
               resp_rdata, resp_fault);
      end else begin
        automatic logic [31:0] e_rd  = exp_q.pop_front();
        automatic logic        e_f   = exp_fault_q.pop_front();
        automatic int          e_lat = exp_lat_q.pop_front();
        automatic int          a_cyc = acc_q.pop_front();
        chk("resp_rdata", resp_rdata, e_rd);
        chk("resp_fault", {31'h0, resp_fault}, {31'h0, e_f});
        if (e_lat >= 0) chk("resp_latency", 32'(cyc - a_cyc), 32'(e_lat));
        resp_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_f, input int lat, input bit push);
    int  n    = 0;
    bit  done = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    while (!done && n < 50) begin
      #1;
      if (req_ready === 1'b1) begin
        done = 1;
        if (push) begin
          exp_q.push_back(exp_rd);
          exp_fault_q.push_back(exp_f);
          exp_lat_q.push_back(lat);
          acc_q.push_back(cyc + 1);
        end
      end
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $error("FAIL req_accept_timeout: observed req_ready %b expected 1 within 50 cycles", req_ready);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL resp_timeout: observed %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
      exp_fault_q.delete();
      exp_lat_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},      {30'h0, dbg_state}, 32'(S_IDLE));
    chk({tag, "_req_ready"},  {31'h0, req_ready}, 32'h0);
    chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_resp_fault"}, {31'h0, resp_fault}, 32'h0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_mem_we"},     {31'h0, mem_WE}, 32'h0);
    chk({tag, "_mem_a"},      mem_A, 32'h0);
    chk({tag, "_mem_wd"},     mem_WD, 32'h0);
    chk({tag, "_mem_ac"},     {29'h0, mem_AddressingControl}, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int we0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_reset", {31'h0, req_ready}, 32'h1);
    @(negedge clk);

    // store then load, one write pulse only
    we0 = we_cnt;
    do_req(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1);
    drain();
    chk("sw_we_pulses", 32'(we_cnt - we0), 32'd1);
    do_req(1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1, 1);
    drain();
    chk("lw_no_we", 32'(we_cnt - we0), 32'd1);

    // load extension
    do_req(1'b0, F3_B,  32'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 1, 1);
    do_req(1'b0, F3_BU, 32'h103, 32'h0, 32'h000000DE, 1'b0, 1, 1);
    do_req(1'b0, F3_H,  32'h102, 32'h0, 32'hFFFFDEAD, 1'b0, 1, 1);
    do_req(1'b0, F3_HU, 32'h102, 32'h0, 32'h0000DEAD, 1'b0, 1, 1);
    drain();

    // illegal encodings: immediate fault response, no write
    we0 = we_cnt;
    do_req(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 0, 1);
    drain();
    do_req(1'b1, 3'b100, 32'h104, 32'h55, 32'h0, 1'b1, 0, 1);
    drain();
    chk("illegal_no_we", 32'(we_cnt - we0), 32'd0);
    do_req(1'b0, F3_W, 32'h104, 32'h0, 32'h0, 1'b0, 1, 1);
    drain();

    // backpressure: response held for 3 cycles
    resp_ready = 1'b0;
    do_req(1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, -1, 1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_resp_valid", {31'h0, resp_valid}, 32'h1);
      chk("bp_resp_rdata", resp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready",  {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    do_req(1'b0, F3_BU, 32'h100, 32'h0, 32'h000000EF, 1'b0, 1, 1);
    #1;
    chk("bp_next_access", {30'h0, dbg_state}, 32'(S_ACCESS));
    drain();

    // back-to-back loads: one response every 2 cycles
    resp_cyc_q.delete();
    do_req(1'b0, F3_W,  32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1, 1);
    do_req(1'b0, F3_BU, 32'h103, 32'h0, 32'h000000DE, 1'b0, 1, 1);
    do_req(1'b0, F3_H,  32'h100, 32'h0, 32'hFFFFBEEF, 1'b0, 1, 1);
    do_req(1'b0, F3_W,  32'h200, 32'h0, 32'hCAFEF00D, 1'b0, 1, 1);
    drain();
    chk("b2b_count", 32'(resp_cyc_q.size()), 32'd4);
    if (resp_cyc_q.size() == 4)
      for (int i = 1; i < 4; i++)
        chk("b2b_spacing", 32'(resp_cyc_q[i] - resp_cyc_q[i-1]), 32'd2);

    // misaligned half store
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1'b1, F3_H,  32'h101, 32'hABCD, 32'h0, 1'b1, 0, 1);
    do_req(1'b0, F3_HU, 32'h101, 32'h0, 32'h0000ADBE, 1'b0, 1, 1);
`else
    do_req(1'b1, F3_H,  32'h101, 32'hABCD, 32'h0, 1'b0, 1, 1);
    do_req(1'b0, F3_HU, 32'h101, 32'h0, 32'h0000ABCD, 1'b0, 1, 1);
`endif
    drain();

    // reset during the ACCESS cycle of a store
    do_req(1'b1, F3_W, 32'h200, 32'h11223344, 32'h0, 1'b0, 0, 0);
    #1;
    chk("mid_state_access", {30'h0, dbg_state}, 32'(S_ACCESS));
    rst = 1'b1;
    #1;
    chk("mid_rst_we_gated", {31'h0, mem_WE}, 32'h0);
    @(negedge clk);
    #1;
    chk_reset_outputs("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    do_req(1'b0, F3_W, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0, 1, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
